// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: command encodings, shifter types,
// forward-select codes, flag bit positions and the stage FSM states.
package exe_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001,
        CMD_MUL = 4'b1010
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_ALU  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_REG2 = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } exe_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_val2_gen.sv
// Combinational second-operand generator.
//   i_imm      : Shift_operand is an 8-bit immediate with 4-bit rotate
//   i_mem_en   : load/store, operand is the raw 12-bit offset
//   i_shift_op : 12-bit shifter operand field
//   i_rm       : forwarded Rm value
//   o_val2     : generated second operand
module exe_val2_gen
    import exe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          i_imm,
    input  logic          i_mem_en,
    input  logic [11:0]   i_shift_op,
    input  logic [DW-1:0] i_rm,
    output logic [DW-1:0] o_val2
);
    localparam int LW = $clog2(DW);

    logic [LW-1:0] w_sh_amt;
    logic [LW-1:0] w_rot_amt;
    logic [DW-1:0] w_imm8;
    logic [DW-1:0] w_shifted;
    shift_e        w_sh_type;

    // Shift by DW (amount 0) yields 0, so the left term vanishes for a=0.
    function automatic logic [DW-1:0] ror(input logic [DW-1:0] x, input logic [LW-1:0] a);
        return (x >> a) | (x << (DW - int'(a)));
    endfunction

    // Amounts are taken modulo DW so narrow datapaths wrap cleanly.
    assign w_sh_amt  = LW'(32'(i_shift_op[11:7]) % 32'(DW));
    assign w_rot_amt = LW'((32'(i_shift_op[11:8]) * 32'd2) % 32'(DW));
    assign w_imm8    = DW'(i_shift_op[7:0]);
    assign w_sh_type = shift_e'(i_shift_op[6:5]);

    always_comb begin
        w_shifted = i_rm;
        case (w_sh_type)
            SH_LSL:  w_shifted = i_rm << w_sh_amt;
            SH_LSR:  w_shifted = i_rm >> w_sh_amt;
            SH_ASR:  w_shifted = $signed(i_rm) >>> w_sh_amt;
            SH_ROR:  w_shifted = ror(i_rm, w_sh_amt);
            default: w_shifted = i_rm;
        endcase
    end

    always_comb begin
        o_val2 = w_shifted;
        if (i_imm)
            o_val2 = ror(w_imm8, w_rot_amt);
        else if (i_mem_en)
            o_val2 = DW'(i_shift_op);
    end

endmodule

// File: rtl/exe_stage_mc.sv
// Registered execute stage with forwarding, Val2 generation, ALU, branch
// target and an iterative MUL_K-bit-per-cycle multiplier.
//   clk/rst          : clock, synchronous active-high reset
//   flush            : cancel the accept of this cycle or a running MUL
//   in_valid/in_ready: upstream handshake (in_ready depends on state only)
//   EXE_CMD..status_in: instruction fields and operands from ID/EX
//   out_valid        : one-cycle pulse when res/status/etc. are updated
//   res, Val_Rm_out, Branch_Address, status: registered results
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int MUL_K = 8,
    parameter int IMM_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       EXE_CMD,
    input  logic             MEM_R_en,
    input  logic             MEM_W_en,
    input  logic             imm,
    input  logic [11:0]      Shift_operand,
    input  logic [IMM_W-1:0] Signed_imm,
    input  logic [DW-1:0]    PC_in,
    input  logic [DW-1:0]    Val_Rn,
    input  logic [DW-1:0]    Val_Rm,
    input  logic [DW-1:0]    ALU_res_f,
    input  logic [DW-1:0]    WB_val_f,
    input  logic [1:0]       sel_src1,
    input  logic [1:0]       sel_src2,
    input  logic [3:0]       status_in,
    output logic             out_valid,
    output logic [DW-1:0]    res,
    output logic [DW-1:0]    Val_Rm_out,
    output logic [DW-1:0]    Branch_Address,
    output logic [3:0]       status
);
    localparam int ITER = DW / MUL_K;
    localparam int CW   = $clog2(ITER + 1);

    exe_state_e    r_state, w_state_nxt;
    logic          w_accept;
    exe_cmd_e      w_cmd;
    logic [DW-1:0] w_a, w_rm, w_val2, w_br, w_bop, w_alu_res, w_pp, w_acc_nxt;
    logic [DW:0]   w_sum;
    logic          w_cin;
    logic [3:0]    w_alu_st;

    logic [DW-1:0] r_acc, r_mcand, r_mplier, r_pend_rm, r_pend_br;
    logic [1:0]    r_pend_cv;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic [DW-1:0] r_res, r_rm_out, r_br;
    logic [3:0]    r_status;

    function automatic logic [DW-1:0] fwd(input logic [1:0] sel, input logic [DW-1:0] rv,
                                          input logic [DW-1:0] alu, input logic [DW-1:0] wb);
        case (fwd_sel_e'(sel))
            FWD_ALU: return alu;
            FWD_WB:  return wb;
            default: return rv;
        endcase
    endfunction

    assign w_cmd = exe_cmd_e'(EXE_CMD);
    assign w_a   = fwd(sel_src1, Val_Rn, ALU_res_f, WB_val_f);
    assign w_rm  = fwd(sel_src2, Val_Rm, ALU_res_f, WB_val_f);
    assign w_br  = PC_in + DW'($signed({Signed_imm, 2'b00}));

    exe_val2_gen #(.DW(DW)) u_val2 (
        .i_imm      (imm),
        .i_mem_en   (MEM_R_en | MEM_W_en),
        .i_shift_op (Shift_operand),
        .i_rm       (w_rm),
        .o_val2     (w_val2)
    );

    // Subtraction is a + ~b + carry_in, so C comes out as ARM not-borrow.
    always_comb begin
        w_bop = w_val2;
        w_cin = 1'b0;
        case (w_cmd)
            CMD_ADC: w_cin = status_in[FLAG_C];
            CMD_SUB: begin w_bop = ~w_val2; w_cin = 1'b1; end
            CMD_SBC: begin w_bop = ~w_val2; w_cin = status_in[FLAG_C]; end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, w_a} + {1'b0, w_bop} + (DW+1)'(w_cin);

    always_comb begin
        w_alu_res = '0;
        case (w_cmd)
            CMD_MOV: w_alu_res = w_val2;
            CMD_MVN: w_alu_res = ~w_val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: w_alu_res = w_sum[DW-1:0];
            CMD_AND: w_alu_res = w_a & w_val2;
            CMD_ORR: w_alu_res = w_a | w_val2;
            CMD_EOR: w_alu_res = w_a ^ w_val2;
            default: w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_alu_st = {w_alu_res[DW-1], (w_alu_res == '0), status_in[FLAG_C], status_in[FLAG_V]};
        case (w_cmd)
            CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: ;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                w_alu_st[FLAG_C] = w_sum[DW];
                w_alu_st[FLAG_V] = (w_a[DW-1] == w_bop[DW-1]) && (w_sum[DW-1] != w_a[DW-1]);
            end
            default: w_alu_st = status_in;
        endcase
    end

    // One MUL_K-bit slice of the multiplier per cycle; multiplicand pre-shifted.
    assign w_pp      = r_mcand * DW'(r_mplier[MUL_K-1:0]);
    assign w_acc_nxt = r_acc + w_pp;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    w_accept = 1'b1;
                    if (w_cmd == CMD_MUL) w_state_nxt = ST_MUL_RUN;
                end
            end
            ST_MUL_RUN: if (flush || r_cnt == CW'(1)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_res     <= '0;
            r_rm_out  <= '0;
            r_br      <= '0;
            r_status  <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_pend_rm <= '0;
            r_pend_br <= '0;
            r_pend_cv <= '0;
            r_cnt     <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                if (w_cmd == CMD_MUL) begin
                    // Side outputs are held back until the product is done.
                    r_acc     <= '0;
                    r_mcand   <= w_a;
                    r_mplier  <= w_rm;
                    r_cnt     <= CW'(ITER);
                    r_pend_rm <= w_rm;
                    r_pend_br <= w_br;
                    r_pend_cv <= status_in[FLAG_C:FLAG_V];
                end else begin
                    r_valid  <= 1'b1;
                    r_res    <= w_alu_res;
                    r_rm_out <= w_rm;
                    r_br     <= w_br;
                    r_status <= w_alu_st;
                end
            end else if (r_state == ST_MUL_RUN && !flush) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << MUL_K;
                r_mplier <= r_mplier >> MUL_K;
                r_cnt    <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_valid  <= 1'b1;
                    r_res    <= w_acc_nxt;
                    r_rm_out <= r_pend_rm;
                    r_br     <= r_pend_br;
                    r_status <= {w_acc_nxt[DW-1], (w_acc_nxt == '0), r_pend_cv};
                end
            end
        end
    end

    assign out_valid      = r_valid;
    assign res            = r_res;
    assign Val_Rm_out     = r_rm_out;
    assign Branch_Address = r_br;
    assign status         = r_status;

endmodule

// File: tb/tb_exe_stage_mc.sv
module tb_exe_stage_mc;
    import exe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [3:0]  EXE_CMD;
    logic        MEM_R_en, MEM_W_en, imm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm;
    logic [31:0] PC_in, Val_Rn, Val_Rm, ALU_res_f, WB_val_f;
    logic [1:0]  sel_src1, sel_src2;
    logic [3:0]  status_in;
    logic        out_valid;
    logic [31:0] res, Val_Rm_out, Branch_Address;
    logic [3:0]  status;

    int n_tot = 0;
    int n_bad = 0;

    logic [63:0] prod;
    logic [31:0] e_res;

    always #5 clk = ~clk;

    exe_stage_mc #(.DW(32), .MUL_K(8), .IMM_W(24)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .EXE_CMD(EXE_CMD), .MEM_R_en(MEM_R_en), .MEM_W_en(MEM_W_en), .imm(imm),
        .Shift_operand(Shift_operand), .Signed_imm(Signed_imm), .PC_in(PC_in),
        .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .ALU_res_f(ALU_res_f), .WB_val_f(WB_val_f),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .status_in(status_in),
        .out_valid(out_valid), .res(res), .Val_Rm_out(Val_Rm_out),
        .Branch_Address(Branch_Address), .status(status)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                      input logic im, input logic [11:0] sh, input logic [3:0] st);
        EXE_CMD = cmd; Val_Rn = rn; Val_Rm = rm; imm = im; Shift_operand = sh;
        status_in = st; in_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; EXE_CMD = '0; MEM_R_en = 1'b0;
        MEM_W_en = 1'b0; imm = 1'b0; Shift_operand = '0; Signed_imm = '0; PC_in = '0;
        Val_Rn = '0; Val_Rm = '0; ALU_res_f = '0; WB_val_f = '0; sel_src1 = '0;
        sel_src2 = '0; status_in = '0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_res", res, 0);
        chk("rst_br", Branch_Address, 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_ready", 32'(in_ready), 1);
        rst = 1'b0;

        // ADD 5+7 plus branch target 0x100 + (-1<<2)
        PC_in = 32'h100; Signed_imm = 24'hFFFFFF;
        op(CMD_ADD, 5, 7, 1'b0, 12'h000, 4'b0000);
        tick();
        chk("add_valid", 32'(out_valid), 1);
        chk("add_res", res, 12);
        chk("add_status", 32'(status), 4'b0000);
        chk("add_br", Branch_Address, 32'hFC);
        chk("add_rm", Val_Rm_out, 7);

        // SUB with Rn forwarded from ALU_res_f, back-to-back
        sel_src1 = 2'b01; ALU_res_f = 3;
        op(CMD_SUB, 1, 3, 1'b0, 12'h000, 4'b0000);
        tick();
        chk("sub_valid", 32'(out_valid), 1);
        chk("sub_res", res, 0);
        chk("sub_status", 32'(status), 4'b0110);
        sel_src1 = 2'b00;

        // MOV rotated immediate 0xFF ror 8
        op(CMD_MOV, 0, 0, 1'b1, 12'h4FF, 4'b0000);
        tick();
        chk("movi_res", res, 32'hFF000000);
        chk("movi_status", 32'(status), 4'b1000);

        // EOR with Rm forwarded from WB, ASR #4; logic op keeps C,V
        sel_src2 = 2'b10; WB_val_f = 32'h80000001;
        op(CMD_EOR, 32'hFFFFFFFF, 32'h0, 1'b0, 12'h240, 4'b0011);
        tick();
        chk("eor_res", res, 32'h07FFFFFF);
        chk("eor_status", 32'(status), 4'b0011);
        chk("eor_rm", Val_Rm_out, 32'h80000001);
        sel_src2 = 2'b00;

        // LSR #4 via ADD
        op(CMD_ADD, 0, 32'h80000001, 1'b0, 12'h220, 4'b0000);
        tick();
        chk("lsr_res", res, 32'h08000000);

        // ADC signed overflow
        op(CMD_ADC, 32'h7FFFFFFF, 0, 1'b0, 12'h000, 4'b0010);
        tick();
        chk("adc_res", res, 32'h80000000);
        chk("adc_status", 32'(status), 4'b1001);

        // SBC with borrow: 5-5-1
        op(CMD_SBC, 5, 5, 1'b0, 12'h000, 4'b0000);
        tick();
        chk("sbc_res", res, 32'hFFFFFFFF);
        chk("sbc_status", 32'(status), 4'b1000);

        // Store address: Rn + zero-extended 12-bit offset
        MEM_W_en = 1'b1;
        op(CMD_ADD, 32'h1000, 0, 1'b0, 12'hFFF, 4'b0000);
        tick();
        chk("mem_res", res, 32'h1FFF);
        MEM_W_en = 1'b0;

        // Unknown command passes status through
        op(4'b1111, 9, 9, 1'b0, 12'h000, 4'b0101);
        tick();
        chk("nop_res", res, 0);
        chk("nop_status", 32'(status), 4'b0101);

        in_valid = 1'b0;
        tick();
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_hold", 32'(status), 4'b0101);

        // MUL 0x10001*3 with a second instruction held behind it
        PC_in = 32'h200; Signed_imm = 24'h1;
        op(CMD_MUL, 32'h10001, 3, 1'b0, 12'h000, 4'b0011);
        tick();
        chk("mul_v0", 32'(out_valid), 0);
        PC_in = 32'h300; Signed_imm = 24'h0;
        op(CMD_ADD, 2, 3, 1'b0, 12'h000, 4'b0000);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("mul_busy%0d", i), 32'(in_ready), 0);
            chk($sformatf("mul_nv%0d", i), 32'(out_valid), 0);
        end
        tick();
        chk("mul_valid", 32'(out_valid), 1);
        chk("mul_res", res, 32'h30003);
        chk("mul_status", 32'(status), 4'b0011);
        chk("mul_br", Branch_Address, 32'h204);
        chk("mul_rm", Val_Rm_out, 3);
        chk("mul_ready", 32'(in_ready), 1);
        tick();
        chk("held_valid", 32'(out_valid), 1);
        chk("held_res", res, 5);
        chk("held_br", Branch_Address, 32'h300);
        in_valid = 1'b0;

        // Full-width MUL against a bench product
        PC_in = 32'h400;
        op(CMD_MUL, 32'h12345678, 32'h9ABCDEF0, 1'b0, 12'h000, 4'b0000);
        prod  = 64'(32'h12345678) * 64'(32'h9ABCDEF0);
        e_res = prod[31:0];
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("mul2_nv", 32'(out_valid), 0);
        tick();
        chk("mul2_valid", 32'(out_valid), 1);
        chk("mul2_res", res, e_res);
        chk("mul2_status", 32'(status), {28'b0, e_res[31], (e_res == 0), 2'b00});

        // Flush in the second cycle of a MUL
        PC_in = 32'h500;
        op(CMD_MUL, 7, 9, 1'b0, 12'h000, 4'b1111);
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 0);
        chk("fl_ready", 32'(in_ready), 1);
        tick(); tick(); tick();
        chk("fl_nv", 32'(out_valid), 0);
        chk("fl_res", res, e_res);
        chk("fl_br", Branch_Address, 32'h400);

        // Flush in IDLE blocks the accept
        op(CMD_ADD, 1, 1, 1'b0, 12'h000, 4'b0000);
        flush = 1'b1;
        tick();
        chk("fli_valid", 32'(out_valid), 0);
        chk("fli_res", res, e_res);
        flush = 1'b0; in_valid = 1'b0;

        // Reset during MUL_RUN
        op(CMD_MUL, 3, 3, 1'b0, 12'h000, 4'b0000);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_valid", 32'(out_valid), 0);
        chk("rr_res", res, 0);
        chk("rr_rm", Val_Rm_out, 0);
        chk("rr_br", Branch_Address, 0);
        chk("rr_status", 32'(status), 0);
        chk("rr_ready", 32'(in_ready), 1);
        tick(); tick(); tick(); tick();
        chk("rr_nv", 32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
- Parametrised, registered execute stage for the ARM-style 5-stage pipeline. Sits between the ID/EX and EX/MEM pipeline registers.
- Keeps the existing functions: operand forwarding, Val2 generation, ALU, and branch target computation.
- Adds these functions:
  - a registered result with a valid/ready handshake;
  - an iterative multi-cycle multiplier (MUL) that stalls upstream while busy;
  - a flush input that cancels in-flight work.

Parameters:
- DW, 32, datapath width. Power of two, at least 16.
- MUL_K, 8, multiplier bits retired per cycle. Must divide DW. MUL takes DW/MUL_K iterations.
- IMM_W, 24, branch immediate width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  cancel the accepted or in-progress instruction
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  stage can accept an instruction this cycle
- EXE_CMD  in  4  ALU command
- MEM_R_en, MEM_W_en  in  1 each  memory access flags
- imm  in  1  Shift_operand is a rotated immediate
- Shift_operand  in  12  shifter operand field
- Signed_imm  in  IMM_W  branch offset in words
- PC_in  in  DW  PC from ID/EX
- Val_Rn, Val_Rm  in  DW  register operands
- ALU_res_f, WB_val_f  in  DW  forwarded values from MEM and WB
- sel_src1, sel_src2  in  2  forward select: 00 reg, 01 ALU_res_f, 10 WB_val_f, 11 reg
- status_in  in  4  current {N,Z,C,V}
- out_valid  out  1  result registers valid
- res  out  DW  ALU/MUL result, or memory address
- Val_Rm_out  out  DW  forwarded Rm, used as store data
- Branch_Address  out  DW  PC_in + sign-extended (Signed_imm<<2)
- status  out  4  {N,Z,C,V}

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM goes to IDLE; out_valid=0.
  - res, Val_Rm_out, Branch_Address and status are all 0.
  - in_ready=1 from the following cycle.
- Forward selection is combinational on the accept cycle. Operands are captured at accept and are not re-sampled.
- Val2 generation:
  - If imm=1: zero-extend Shift_operand[7:0], then rotate right by 2*Shift_operand[11:8].
  - Else if MEM_R_en or MEM_W_en: zero-extend Shift_operand[11:0].
  - Else: shift Rm by Shift_operand[11:7] mod DW. Type comes from [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- Commands:
  - 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR.
  - 1010 MUL, low DW bits of Rn*Rm. Uses the forwarded Rm, not Val2.
  - Other codes give res=0 and status=status_in.
- Flags:
  - N = res[DW-1]; Z = (res==0).
  - ADD, ADC, SUB and SBC compute C and V. SBC uses borrow = ~status_in.C. SUB C is the ARM not-borrow.
  - Logic ops and MUL keep C and V from status_in.
- FSM states:
  - IDLE: in_ready=1. Accept fires when in_valid=1 and flush=0.
    - Non-MUL: result is registered at the same edge, out_valid=1 for exactly one cycle (latency 1). Back-to-back accepts are allowed.
    - MUL: go to MUL_RUN and load the counter with DW/MUL_K. out_valid=0 on the next cycle.
  - MUL_RUN: in_ready=0. Each cycle, add the partial product of the next MUL_K multiplier bits (LSB first) and decrement the counter. When the counter reaches 1, the next edge registers res, sets out_valid=1 and returns to IDLE.
  - Total MUL latency = DW/MUL_K cycles from accept to out_valid.
- in_ready is combinational from the FSM state only. It never depends on in_valid.
- flush=1:
  - In IDLE: no accept; out_valid=0 next cycle.
  - In MUL_RUN: abort to IDLE; out_valid=0; no result or status update.
  - flush dominates in_valid.
- rst dominates flush.
- Branch_Address, Val_Rm_out and status are registered with res and update only when out_valid rises. They hold their values otherwise.

Decomposition:
- Shared package exe_pkg:
  - EXE_CMD encodings including CMD_MUL.
  - Shift type codes.
  - Forward-select codes.
  - Flag bit indices N=3, Z=2, C=1, V=0.
- One sub-module, exe_val2_gen: the combinational Val2 generator, parametrised by DW.
- ALU, multiplier datapath and FSM stay in the top module.

Test Plan:
- ADD, Rn=5, Rm=7, sel=00, imm=0, shift 0: next cycle out_valid=1, res=12, status=0000.
- SUB with forwarding: Rn reg=1, sel_src1=01, ALU_res_f=3, Rm=3: res=0, status N=0 Z=1 C=1 V=0.
- Immediate Val2: imm=1, Shift_operand=0x4FF, MOV: res=0xFF000000, N=1.
- MUL, DW=32, MUL_K=8, Rn=0x10001, Rm=3, status_in C=1 V=1:
  - in_ready=0 for 3 cycles;
  - out_valid exactly 4 cycles after accept, with res=0x30003, C=1, V=1;
  - a second in_valid held during the MUL is accepted only after the result.
- Flush mid-MUL in cycle 2: FSM returns to IDLE, out_valid stays 0, registered outputs keep their prior values, in_ready=1 next cycle.
- rst asserted during MUL_RUN: next cycle out_valid=0, all outputs 0, in_ready=1.
- Branch: PC_in=0x100, Signed_imm=0xFFFFFF: Branch_Address=0xFC.
